fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  hazard hold; freezes PC and if_* outputs.
REQ-005 SHALL have port branch  input  1  and branch_addr  input  32  taken-branch redirect and its target.
REQ-006 SHALL have port jump  input  1  and jump_addr  input  32  jump redirect and its target.
REQ-007 SHALL have port imem_req  output  1  and imem_addr  output  32  instruction memory request and word address.
REQ-008 SHALL have port imem_ack  input  1  and imem_rdata  input  32  memory completion strobe and instruction word.
REQ-009 SHALL have ports if_pc, if_pc_plus4, if_inst  output  32 each: fetched instruction, its PC and PC+4, to the IF/ID register.
REQ-010 SHALL have port if_valid  output  1  (if_inst is real) and flush  output  1  (kill the younger IF/ID contents).

Function
REQ-011 SHALL implement states BOOT, REQ, HOLD, DRAIN.
REQ-012 SHALL keep internal pc register; imem_addr SHALL equal {pc[31:2],2'b00}.
REQ-013 SHALL assert imem_req exactly in REQ and DRAIN; once asserted, imem_req and imem_addr SHALL stay stable until an imem_ack cycle.
REQ-014 SHALL treat imem_ack as meaningful only while imem_req=1; ack in the same cycle as req gives one instruction per cycle.
REQ-015 BOOT SHALL last one cycle after reset release, then go to REQ.
REQ-016 REQ, ack, stall=0, no redirect: if_inst<=imem_rdata, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4; stay REQ.
REQ-017 REQ, no ack, stall=0: if_valid<=0, if_inst<=32'h0 (NOP); pc unchanged.
REQ-018 REQ, ack, stall=1: capture rdata/pc into a skid buffer; if_* hold; go HOLD (imem_req=0).
REQ-019 REQ or HOLD with stall=1 and no ack: all if_* outputs and pc SHALL hold.
REQ-020 HOLD, stall=0: if_* <= skid contents, if_valid<=1, pc<=pc+4; go REQ.
REQ-021 Redirect = jump|branch; jump SHALL have priority over branch when both are asserted.
REQ-022 Redirect SHALL override stall; on a redirect cycle flush=1 (combinational, that cycle only), if_valid<=0, if_inst<=NOP, pc<=target with bits[1:0] cleared.
REQ-023 Redirect in REQ without ack: go DRAIN; the old request SHALL complete unchanged and its data SHALL be discarded, then go REQ at the new pc.
REQ-024 Redirect in REQ with ack that cycle, or in HOLD: response/skid discarded; go REQ at target next cycle.
REQ-025 Redirect in DRAIN: pc<=newest target; stay DRAIN until ack.
REQ-026 Redirect in BOOT: pc<=target; go REQ.
REQ-027 pc+4 SHALL be 32-bit modulo: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 flush SHALL be 0 whenever no redirect is asserted.

Reset
REQ-029 On rst=0, asynchronously: state=BOOT, pc=RESET_PC, skid cleared, if_pc=0, if_pc_plus4=0, if_inst=0, if_valid=0; imem_req=0; flush=0.
REQ-030 Reset mid-request SHALL abandon the outstanding access; an imem_ack arriving in BOOT SHALL be ignored.

Structure
REQ-031 State encoding, NOP value (32'h0) and PC increment (4) SHALL live in the shared mips_pkg package.
REQ-032 The PC+4 computation SHALL reuse the existing Adder module; no other sub-module.

Verification
REQ-033 Reset, then ack every cycle -> imem_addr 0,4,8,C on consecutive cycles; if_valid=1 from the second fetch cycle; if_pc matches.
REQ-034 Ack with 2-cycle latency -> imem_addr held 3 cycles; if_valid=0 for two cycles, then if_inst=rdata.
REQ-035 Ack while stall=1 for 3 cycles at pc=0x10 -> outputs frozen; skid delivered with if_pc=0x10 on stall release; next imem_addr=0x14.
REQ-036 jump=1 (0x400) and branch=1 (0x200) in the same cycle -> flush=1 one cycle; next imem_addr=0x400.
REQ-037 branch to 0x80 while a fetch of 0x20 is pending -> imem_addr held at 0x20 until ack, data discarded (if_valid=0), then imem_addr=0x80.
REQ-038 RESET_PC=32'hFFFF_FFFC, ack every cycle -> second fetch address 0x0; rst pulsed low mid-request -> imem_req=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: controller states, the NOP encoding and the PC step.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_controller_adder.sv
// Plain combinational adder, wraps modulo 2**W.
module Adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: drives the instruction memory handshake, absorbs
// stalls through a one-entry skid buffer and discards responses killed by redirects.
module fetch_controller
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_addr,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        flush
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  skid_inst_q, skid_inst_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic         if_valid_q, if_valid_d;

    logic [31:0]  pc_plus4;
    logic         redirect;
    logic [31:0]  target;
    logic         ack;

    Adder #(.W(32)) u_pc_adder (
        .a (pc_q),
        .b (PC_INC),
        .y (pc_plus4)
    );

    assign redirect = jump | branch;
    assign target   = jump ? {jump_addr[31:2], 2'b00} : {branch_addr[31:2], 2'b00};

    assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    // While draining, the abandoned request must stay on the bus untouched even
    // though pc already points at the redirect target.
    assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : {pc_q[31:2], 2'b00};
    assign ack       = imem_ack & imem_req;
    assign flush     = redirect & rst;

    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_inst     = if_inst_q;
    assign if_valid    = if_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        skid_inst_d   = skid_inst_q;
        skid_pc_d     = skid_pc_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_inst_d     = if_inst_q;
        if_valid_d    = if_valid_q;

        if (redirect) begin
            pc_d       = target;
            if_valid_d = 1'b0;
            if_inst_d  = NOP;
        end

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    if (!ack) begin
                        state_d      = ST_DRAIN;
                        drain_addr_d = {pc_q[31:2], 2'b00};
                    end
                end else if (ack && !stall) begin
                    if_inst_d     = imem_rdata;
                    if_pc_d       = pc_q;
                    if_pc_plus4_d = pc_plus4;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_plus4;
                end else if (ack) begin
                    skid_inst_d = imem_rdata;
                    skid_pc_d   = pc_q;
                    state_d     = ST_HOLD;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    if_inst_d  = NOP;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d = ST_REQ;
                end else if (!stall) begin
                    // pc was not advanced when the skid was filled, so pc_plus4 is skid_pc+4.
                    if_inst_d     = skid_inst_q;
                    if_pc_d       = skid_pc_q;
                    if_pc_plus4_d = pc_plus4;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_plus4;
                    state_d       = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if_valid_d = 1'b0;
                if_inst_d  = NOP;
                if (ack) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            drain_addr_q  <= 32'h0;
            skid_inst_q   <= 32'h0;
            skid_pc_q     <= 32'h0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
            if_inst_q     <= NOP;
            if_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc_q     <= skid_pc_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_inst_q     <= if_inst_d;
            if_valid_q    <= if_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: stimulus pushes the expected per-cycle view
// into a scoreboard queue, a negedge monitor pops it and compares against the DUT.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst0 = 1'b0;
    logic        rst1 = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    logic        req0, req1, vld0, vld1, fl0, fl1;
    logic [31:0] addr0, addr1, pc0, pc1, p40, p41, inst0, inst1;

    always #5 clk = ~clk;

    fetch_controller dut0 (
        .clk(clk), .rst(rst0), .stall(stall),
        .branch(branch), .branch_addr(branch_addr),
        .jump(jump), .jump_addr(jump_addr),
        .imem_req(req0), .imem_addr(addr0),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_pc(pc0), .if_pc_plus4(p40), .if_inst(inst0),
        .if_valid(vld0), .flush(fl0)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst1), .stall(stall),
        .branch(branch), .branch_addr(branch_addr),
        .jump(jump), .jump_addr(jump_addr),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_pc(pc1), .if_pc_plus4(p41), .if_inst(inst1),
        .if_valid(vld1), .flush(fl1)
    );

    typedef struct {
        logic        sel;
        logic        rq;
        logic [31:0] ad;
        logic        fl;
        logic        vl;
        logic [31:0] pc;
        logic [31:0] p4;
        logic [31:0] inst;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL txn %0d %s: got %h expected %h", n_txn, nm, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per cycle the stimulus announced.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_txn++;
            $display("txn %0d dut%0d: req=%0b addr=%h flush=%0b valid=%0b pc=%h pc4=%h inst=%h",
                     n_txn, e.sel,
                     e.sel ? req1 : req0, e.sel ? addr1 : addr0, e.sel ? fl1 : fl0,
                     e.sel ? vld1 : vld0, e.sel ? pc1 : pc0, e.sel ? p41 : p40,
                     e.sel ? inst1 : inst0);
            chk("imem_req",    {31'h0, e.sel ? req1 : req0}, {31'h0, e.rq});
            chk("imem_addr",   e.sel ? addr1 : addr0,        e.ad);
            chk("flush",       {31'h0, e.sel ? fl1 : fl0},   {31'h0, e.fl});
            chk("if_valid",    {31'h0, e.sel ? vld1 : vld0}, {31'h0, e.vl});
            chk("if_pc",       e.sel ? pc1 : pc0,            e.pc);
            chk("if_pc_plus4", e.sel ? p41 : p40,            e.p4);
            chk("if_inst",     e.sel ? inst1 : inst0,        e.inst);
        end
    end

    // Drive one cycle of inputs, announce the expected outputs, advance past the edge.
    task automatic cyc(input logic sel, input logic r, input logic st,
                       input logic j, input logic [31:0] ja,
                       input logic b, input logic [31:0] ba,
                       input logic ak, input logic [31:0] rd,
                       input logic rq, input logic [31:0] ad, input logic fl,
                       input logic vl, input logic [31:0] pc, input logic [31:0] p4,
                       input logic [31:0] inst);
        exp_t e;
        if (sel) rst1 = r; else rst0 = r;
        stall = st; jump = j; jump_addr = ja; branch = b; branch_addr = ba;
        imem_ack = ak; imem_rdata = rd;
        e.sel = sel; e.rq = rq; e.ad = ad; e.fl = fl; e.vl = vl;
        e.pc = pc; e.p4 = p4; e.inst = inst;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        //   sel r st j ja            b ba            ak rd              rq ad             fl vl pc             p4             inst
        cyc(0, 0, 0, 1, 32'h400,      0, 32'h0,       0, 32'h0,          0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hBAD0_0000,  0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        // back-to-back fetches
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hA000_0000,  1, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hA000_0001,  1, 32'h4,         0, 1, 32'h0,         32'h4,         32'hA000_0000);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hA000_0002,  1, 32'h8,         0, 1, 32'h4,         32'h8,         32'hA000_0001);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hA000_0003,  1, 32'hC,         0, 1, 32'h8,         32'hC,         32'hA000_0002);
        // ack under stall at pc 0x10, three stall cycles
        cyc(0, 1, 1, 0, 32'h0,        0, 32'h0,       1, 32'h5000_0010,  1, 32'h10,        0, 1, 32'hC,         32'h10,        32'hA000_0003);
        cyc(0, 1, 1, 0, 32'h0,        0, 32'h0,       1, 32'hBAD0_0001,  0, 32'h10,        0, 1, 32'hC,         32'h10,        32'hA000_0003);
        cyc(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 32'h0,          0, 32'h10,        0, 1, 32'hC,         32'h10,        32'hA000_0003);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,          0, 32'h10,        0, 1, 32'hC,         32'h10,        32'hA000_0003);
        // skid delivered, then a two-cycle-latency fetch of 0x14
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,          1, 32'h14,        0, 1, 32'h10,        32'h14,        32'h5000_0010);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,          1, 32'h14,        0, 0, 32'h10,        32'h14,        32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'h1A70_0014,  1, 32'h14,        0, 0, 32'h10,        32'h14,        32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,          1, 32'h18,        0, 1, 32'h14,        32'h18,        32'h1A70_0014);
        // jump and branch together, with ack: jump wins
        cyc(0, 1, 0, 1, 32'h400,      1, 32'h200,     1, 32'hBAD0_0002,  1, 32'h18,        1, 0, 32'h14,        32'h18,        32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'h0400_0400,  1, 32'h400,       0, 0, 32'h14,        32'h18,        32'h0);
        // unaligned jump to 0x22 without ack: drain old 0x404
        cyc(0, 1, 0, 1, 32'h22,       0, 32'h0,       0, 32'h0,          1, 32'h404,       1, 1, 32'h400,       32'h404,       32'h0400_0400);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hBAD0_0003,  1, 32'h404,       0, 0, 32'h400,       32'h404,       32'h0);
        // branch to 0x80 while 0x20 pending
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,          1, 32'h20,        0, 0, 32'h400,       32'h404,       32'h0);
        cyc(0, 1, 0, 0, 32'h0,        1, 32'h80,      0, 32'h0,          1, 32'h20,        1, 0, 32'h400,       32'h404,       32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,          1, 32'h20,        0, 0, 32'h400,       32'h404,       32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hDEAD_0020,  1, 32'h20,        0, 0, 32'h400,       32'h404,       32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hB000_0080,  1, 32'h80,        0, 0, 32'h400,       32'h404,       32'h0);
        // stall with no ack: everything holds
        cyc(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 32'h0,          1, 32'h84,        0, 1, 32'h80,        32'h84,        32'hB000_0080);
        cyc(0, 1, 1, 0, 32'h0,        0, 32'h0,       0, 32'h0,          1, 32'h84,        0, 1, 32'h80,        32'h84,        32'hB000_0080);
        // second instance: RESET_PC at the top of the address space
        cyc(1, 1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,          0, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0,         32'h0);
        cyc(1, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hE000_0000,  1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0,         32'h0);
        cyc(1, 1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,          1, 32'h0,         0, 1, 32'hFFFF_FFFC, 32'h0,         32'hE000_0000);
        // reset pulse mid-request, redirect asserted during reset
        cyc(1, 0, 0, 0, 32'h0,        1, 32'h300,     0, 32'h0,          0, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0,         32'h0);
        cyc(1, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hBAD0_0004,  0, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0,         32'h0);
        cyc(1, 1, 0, 0, 32'h0,        0, 32'h0,       1, 32'hE000_0001,  1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'h0,         32'h0);
        cyc(1, 1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,          1, 32'h0,         0, 1, 32'hFFFF_FFFC, 32'h0,         32'hE000_0001);

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
